serial_subtractor: RTL

//   Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor.sv | 90 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor step per clock.
// Define SERIAL_SUB_COMPARE_EN to add the eq / lt flags; otherwise they are tied low.
module serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             eq,
  output logic             lt
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d, borrow_q, borrow_d;
  logic             d, bo, accept, shifting, last;
  always_comb begin
    d        = a_q[0] ^ b_q[0] ^ bin_q;
    bo       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    shifting = state_q == SHIFT;
    accept   = start && !shifting;
    last     = shifting && cnt_q == CW'(WIDTH - 1);
    state_d  = accept ? SHIFT : last ? DONE : shifting ? SHIFT : IDLE;
    a_d      = accept ? a : shifting ? a_q >> 1 : a_q;
    b_d      = accept ? b : shifting ? b_q >> 1 : b_q;
    res_d    = shifting ? {d, res_q[WIDTH-1:1]} : res_q;
    bin_d    = accept ? 1'b0 : shifting ? bo : bin_q;
    cnt_d    = accept ? '0 : shifting ? cnt_q + CW'(1) : cnt_q;
    diff_d   = last ? {d, res_q[WIDTH-1:1]} : diff_q;
    borrow_d = last ? bo : borrow_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end
  assign busy   = state_q == SHIFT;
  assign done   = state_q == DONE;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_COMPARE_EN
  // Any nonzero difference bit, including the last one, means a != b.
  logic nz_q, nz_d, eq_q, eq_d, lt_q, lt_d;
  always_comb begin
    nz_d = accept ? 1'b0 : shifting ? nz_q | d : nz_q;
    eq_d = last ? ~(nz_q | d) : eq_q;
    lt_d = last ? bo : lt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nz_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      nz_q <= nz_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
    end
  end
  assign eq = eq_q;
  assign lt = lt_q;
`else
  assign eq = 1'b0;
  assign lt = 1'b0;
`endif
endmodule
